// File: rtl/instruction_fetch_sequencer.sv
// Fetch sequencer for a registered-read instruction memory: owns the PC, handles redirect/stall/enable.
// Optional halt-on-zero-word detection is enabled by defining FETCH_HALT_DETECT_EN.
module instruction_fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_address,
  input  logic [31:0] mem_instruction,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] fetch_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_if_instruction;
  logic [31:0] r_if_pc;
  logic [31:0] r_fetch_count;
  logic        r_if_valid;
  logic        r_halted;

  logic        w_slot_free;
  logic        w_advance;
  logic        w_xfer;
  logic        w_halt_hit;
  logic [31:0] w_pc_next;

  assign w_slot_free = !r_if_valid || if_ready;
  assign w_advance   = (r_state == S_RUN) && w_slot_free && !branch_taken;
  assign w_xfer      = r_if_valid && if_ready && !branch_taken;
  assign w_pc_next   = r_fetch_pc + PC_STEP;

`ifdef FETCH_HALT_DETECT_EN
  assign w_halt_hit = w_advance && (mem_instruction == 32'h0000_0000);
`else
  assign w_halt_hit = 1'b0;
`endif

  // Address steering: memory must see next cycle's PC this cycle, so if_ready reaches here combinationally.
  always_comb begin
    mem_address = r_fetch_pc;
    if (branch_taken) begin
      mem_address = branch_target;
    end else if (w_advance && !w_halt_hit) begin
      mem_address = w_pc_next;
    end else begin
      mem_address = r_fetch_pc;
    end
  end

  // Sequencer state, PC, output stage and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_fetch_pc       <= RESET_PC;
      r_if_valid       <= 1'b0;
      r_if_instruction <= 32'd0;
      r_if_pc          <= 32'd0;
      r_fetch_count    <= 32'd0;
      r_halted         <= 1'b0;
    end else if (branch_taken) begin
      // Redirect flushes the output stage; the concurrent handshake is not counted.
      r_fetch_pc <= branch_target;
      r_if_valid <= 1'b0;
      r_halted   <= 1'b0;
      case (r_state)
        S_IDLE:  r_state <= S_IDLE;
        S_FILL:  r_state <= S_FILL;
        S_RUN:   r_state <= S_FILL;
        S_HALT:  r_state <= enable ? S_FILL : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end else begin
      if (w_xfer) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_if_valid <= 1'b0;
          end
          if (enable) begin
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_xfer) begin
            r_if_valid <= 1'b0;
          end
          r_state <= enable ? S_RUN : S_IDLE;
        end
        S_RUN: begin
          if (w_advance) begin
            r_if_valid       <= 1'b1;
            r_if_instruction <= mem_instruction;
            r_if_pc          <= r_fetch_pc;
            if (w_halt_hit) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_fetch_pc <= w_pc_next;
              r_state    <= enable ? S_RUN : S_IDLE;
            end
          end else begin
            r_state <= enable ? S_RUN : S_IDLE;
          end
        end
        S_HALT: begin
          if (w_xfer) begin
            r_if_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_valid       = r_if_valid;
  assign if_instruction = r_if_instruction;
  assign if_pc          = r_if_pc;
  assign fetch_count    = r_fetch_count;
  assign halted         = r_halted;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a registered-read memory model.
module tb_instruction_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] mem_address;
  logic [31:0] mem_instruction;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] fetch_count;
  logic        halted;

  logic [31:0] mem [16];
  int checks;
  int failures;

  instruction_fetch_sequencer #(
    .RESET_PC(32'd0),
    .PC_STEP (32'd1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .mem_address    (mem_address),
    .mem_instruction(mem_instruction),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .fetch_count    (fetch_count),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_instruction <= mem[mem_address[3:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] word, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_instr"}, if_instruction, word);
    chk({tag, "_pc"}, if_pc, pc);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) mem[i] = (i < 10) ? 32'(10 - i) : 32'(100 + i);
    mem_instruction = 32'd0;
    rst_n = 1'b0;
    enable = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'd0;
    if_ready = 1'b1;

    tick(); tick();
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_instr", if_instruction, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", {31'd0, if_valid}, 32'd0);

    // Start streaming: two-cycle latency from enable.
    enable = 1'b1;
    tick();
    chk("fill_valid", {31'd0, if_valid}, 32'd0);
    chk("fill_addr", mem_address, 32'd0);
    tick();
    chk("run_valid", {31'd0, if_valid}, 32'd0);
    chk("run_addr", mem_address, 32'd1);
    tick();
    chk_word("w10", 32'd10, 32'd0);
    chk("cnt0", fetch_count, 32'd0);
    tick();
    chk_word("w9", 32'd9, 32'd1);
    tick();
    chk_word("w8", 32'd8, 32'd2);
    chk("cnt2", fetch_count, 32'd2);

    // Backpressure for three cycles while word 8 is presented.
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_word("stall", 32'd8, 32'd2);
      chk("stall_addr", mem_address, 32'd3);
      chk("stall_cnt", fetch_count, 32'd2);
    end
    if_ready = 1'b1;
    tick();
    chk_word("w7", 32'd7, 32'd3);
    chk("cnt3", fetch_count, 32'd3);
    tick();
    chk_word("w6", 32'd6, 32'd4);
    chk("cnt4", fetch_count, 32'd4);

    // Redirect to 7 with a live handshake: flushed and not counted.
    branch_taken = 1'b1;
    branch_target = 32'd7;
    #1;
    chk("br_addr", mem_address, 32'd7);
    tick();
    branch_taken = 1'b0;
    chk("br_flush", {31'd0, if_valid}, 32'd0);
    chk("br_cnt", fetch_count, 32'd4);
    tick();
    chk("br_flush2", {31'd0, if_valid}, 32'd0);
    tick();
    chk_word("b3", 32'd3, 32'd7);
    chk("b3_cnt", fetch_count, 32'd4);
    tick();
    chk_word("b2", 32'd2, 32'd8);
    tick();
    chk_word("b1", 32'd1, 32'd9);
    chk("b1_cnt", fetch_count, 32'd6);

    // Redirect to 3, then drop enable so pc 4 is the last load.
    branch_taken = 1'b1;
    branch_target = 32'd3;
    tick();
    branch_taken = 1'b0;
    chk("br2_cnt", fetch_count, 32'd6);
    tick();
    tick();
    chk_word("r7", 32'd7, 32'd3);
    enable = 1'b0;
    tick();
    chk_word("r6", 32'd6, 32'd4);
    chk("dis_addr", mem_address, 32'd5);
    chk("dis_cnt", fetch_count, 32'd7);
    tick();
    chk("drain_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_cnt", fetch_count, 32'd8);
    tick();
    chk("idle_hold_valid", {31'd0, if_valid}, 32'd0);
    chk("idle_hold_addr", mem_address, 32'd5);
    enable = 1'b1;
    tick();
    chk("re_fill", {31'd0, if_valid}, 32'd0);
    tick();
    chk("re_run", {31'd0, if_valid}, 32'd0);
    tick();
    chk_word("re5", 32'd5, 32'd5);
    chk("re5_cnt", fetch_count, 32'd8);

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_cnt", fetch_count, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_addr", mem_address, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk_word("pr10", 32'd10, 32'd0);
    mem[3] = 32'd0;
    tick();
    chk_word("pr9", 32'd9, 32'd1);
    tick();
    chk_word("pr8", 32'd8, 32'd2);
    tick();
    chk_word("z0", 32'd0, 32'd3);
    chk("z_cnt", fetch_count, 32'd3);
`ifdef FETCH_HALT_DETECT_EN
    chk("halt_set", {31'd0, halted}, 32'd1);
    chk("halt_addr", mem_address, 32'd3);
    tick();
    chk("halt_drain", {31'd0, if_valid}, 32'd0);
    chk("halt_cnt", fetch_count, 32'd4);
    chk("halt_hold", {31'd0, halted}, 32'd1);
    chk("halt_addr2", mem_address, 32'd3);
    branch_taken = 1'b1;
    branch_target = 32'd0;
    tick();
    branch_taken = 1'b0;
    chk("halt_clr", {31'd0, halted}, 32'd0);
    chk("halt_br_valid", {31'd0, if_valid}, 32'd0);
    tick();
    tick();
    chk_word("hr10", 32'd10, 32'd0);
`else
    chk("nohalt", {31'd0, halted}, 32'd0);
    tick();
    chk_word("z_next", 32'd6, 32'd4);
    chk("z_next_cnt", fetch_count, 32'd4);
    chk("nohalt2", {31'd0, halted}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
